test_monitor: RTL

- Simulation/FPGA self-check peripheral that sits directly downstream of the multicycle cpu, snooping its memory bus and fetch strobe.
- Replaces fixed-delay test termination with a defined end-of-test event.
- Detects pass/fail stores to a "tohost" word, self-loop hangs, and cycle timeouts.
- Reports a sticky status plus cycle and instruction counts that the bench prints and then calls $finish on.

---
 rtl/test_monitor_pkg.sv | 16 +
 rtl/test_monitor_sat_counter.sv | 32 +++
 rtl/test_monitor.sv | 122 ++++++++++++
 3 files changed

// File: rtl/test_monitor_pkg.sv
// Shared encodings for the end-of-test monitor: status values, hang codes
// and the default address of the tohost result word.
package test_monitor_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_PASS = 2'b01,
    ST_FAIL = 2'b10,
    ST_HANG = 2'b11
  } state_e;

  localparam logic [31:0] FAIL_TIMEOUT     = 32'hFFFF_FFFF;
  localparam logic [31:0] FAIL_SPIN        = 32'hFFFF_FFFE;
  localparam logic [31:0] DEF_TOHOST_ADDR  = 32'h0000_3FFC;

endpackage

// File: rtl/test_monitor_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (en && (count_q != {WIDTH{1'b1}}))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/test_monitor.sv
// Observational end-of-test monitor: snoops cpu stores and fetches and latches
// a sticky PASS/FAIL/HANG verdict together with cycle and fetch counts.
module test_monitor
  import test_monitor_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR    = DEF_TOHOST_ADDR,
  parameter int          TIMEOUT_CYCLES = 2048,
  parameter int          SPIN_LIMIT     = 8,
  parameter int          CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_we,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic             fetch,
  input  logic [31:0]      pc,
  output logic             done,
  output logic [1:0]       status,
  output logic [31:0]      fail_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] fetch_count
);

  localparam int SPIN_W = $clog2(SPIN_LIMIT) + 1;

  state_e            state_q, state_d;
  logic              done_q, done_d;
  logic [31:0]       fail_code_q, fail_code_d;
  logic [31:0]       last_pc_q, last_pc_d;
  logic [SPIN_W-1:0] spin_q, spin_d;

  logic running;
  logic samePc;
  logic tohostHit;
  logic spinHit;
  logic timeoutHit;

  assign running    = (state_q == ST_RUN);
  assign samePc     = (pc == last_pc_q);
  assign tohostHit  = running && mem_we && (mem_addr == TOHOST_ADDR) && (mem_wdata != 32'd0);
  assign spinHit    = running && fetch && samePc &&
                      ((spin_q + 1'b1) == SPIN_W'(SPIN_LIMIT - 1));
  assign timeoutHit = running && (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));

  sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (running),
    .clr   (1'b0),
    .count (cycle_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_fetch_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (running && fetch),
    .clr   (1'b0),
    .count (fetch_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= ST_RUN;
    else
      state_q <= state_d;
  end

  // A tohost store beats a spin hang, which beats a timeout.
  always_comb begin
    state_d = state_q;
    if (tohostHit)
      state_d = (mem_wdata == 32'd1) ? ST_PASS : ST_FAIL;
    else if (spinHit || timeoutHit)
      state_d = ST_HANG;
  end

  always_comb begin
    fail_code_d = fail_code_q;
    done_d      = (state_d != ST_RUN);
    if (tohostHit)
      fail_code_d = (mem_wdata == 32'd1) ? 32'd0 : {1'b0, mem_wdata[31:1]};
    else if (spinHit)
      fail_code_d = FAIL_SPIN;
    else if (timeoutHit)
      fail_code_d = FAIL_TIMEOUT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q      <= 1'b0;
      fail_code_q <= 32'd0;
    end else begin
      done_q      <= done_d;
      fail_code_q <= fail_code_d;
    end
  end

  always_comb begin
    last_pc_d = last_pc_q;
    spin_d    = spin_q;
    if (running && fetch) begin
      last_pc_d = pc;
      spin_d    = samePc ? spin_q + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_pc_q <= 32'd0;
      spin_q    <= '0;
    end else begin
      last_pc_q <= last_pc_d;
      spin_q    <= spin_d;
    end
  end

  assign done      = done_q;
  assign status    = state_q;
  assign fail_code = fail_code_q;

endmodule
